// File: rtl/counter_sat_if.sv
// Bundle of step, reinit and status signals for one saturating/wrapping counter.
// The master drives steps and reinit, and the slave is the counter.
interface counter_sat_if #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 2
);
    logic                  reinit;
    logic [WIDTH-1:0]      initial_value;
    logic                  incr_valid;
    logic [STEP_WIDTH-1:0] incr;
    logic                  decr_valid;
    logic [STEP_WIDTH-1:0] decr;
    logic                  clr_flags;
    logic [WIDTH-1:0]      value;
    logic [WIDTH-1:0]      value_next;
    logic                  overflow;
    logic                  underflow;
    logic                  is_zero;
    logic                  is_max;

    modport master (
        output reinit, initial_value, incr_valid, incr, decr_valid, decr, clr_flags,
        input  value, value_next, overflow, underflow, is_zero, is_max
    );

    modport slave (
        input  reinit, initial_value, incr_valid, incr, decr_valid, decr, clr_flags,
        output value, value_next, overflow, underflow, is_zero, is_max
    );
endinterface

// File: rtl/counter_sat.sv
// Up/down event counter with saturate-or-wrap mode, sticky range flags and
// a zero-cycle value_next look-ahead. Used for credit/occupancy tracking.
module counter_sat #(
    parameter int              WIDTH       = 8,
    parameter int              STEP_WIDTH  = 2,
    parameter bit              SATURATE    = 1'b1,
    parameter logic [WIDTH-1:0] MAX_VALUE   = '1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic          clk,
    input logic          rst,
    counter_sat_if.slave bus
);
    localparam int RW = WIDTH + 2;
    localparam logic [WIDTH-1:0] CEIL = SATURATE ? MAX_VALUE : {WIDTH{1'b1}};

    logic [WIDTH-1:0]      value_q, value_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [WIDTH-1:0]      value_next;
    logic [STEP_WIDTH-1:0] inc, dec;
    logic [RW-1:0]         raw;
    logic                  ovf_cond, unf_cond, upd;

    // raw is two's complement in WIDTH+2 bits, so bit RW-1 marks a negative result
    always_comb begin
        inc        = bus.incr_valid ? bus.incr : '0;
        dec        = bus.decr_valid ? bus.decr : '0;
        raw        = {2'b00, value_q}
                     + {{(RW-STEP_WIDTH){1'b0}}, inc}
                     - {{(RW-STEP_WIDTH){1'b0}}, dec};
        ovf_cond   = 1'b0;
        unf_cond   = 1'b0;
        value_next = raw[WIDTH-1:0];
        if (bus.reinit) begin
            if (SATURATE && (bus.initial_value > MAX_VALUE))
                value_next = MAX_VALUE;
            else
                value_next = bus.initial_value;
        end else if (raw[RW-1]) begin
            unf_cond = 1'b1;
            if (SATURATE)
                value_next = '0;
        end else if (raw[RW-2:0] > {1'b0, CEIL}) begin
            ovf_cond = 1'b1;
            if (SATURATE)
                value_next = MAX_VALUE;
        end
    end

    always_comb begin
        upd         = bus.reinit | bus.incr_valid | bus.decr_valid;
        value_d     = upd ? value_next : value_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // a fresh set beats a simultaneous clear
        if (upd && !bus.reinit && ovf_cond)
            overflow_d = 1'b1;
        if (upd && !bus.reinit && unf_cond)
            underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q     <= RESET_VALUE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            value_q     <= value_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.value_next = value_next;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.is_zero    = (value_q == '0);
    assign bus.is_max     = (value_q == CEIL);
endmodule
